// File: rtl/fwd_source_pkg.sv
// fwd_source_pkg: shared definitions for the operand bypass producer.
//   FWD_BUS_WD   width of every bypass bus {we, waddr, wdata}
//   FWD_WE_BIT   position of the write-enable bit on a bus
//   FWD_ADDR_*   position of the destination register field on a bus
//   fwd_slot_t   record held by one pipeline stage slot (MEM or WB)
package fwd_source_pkg;

   localparam int FWD_BUS_WD  = 38;
   localparam int FWD_WE_BIT  = 37;
   localparam int FWD_ADDR_HI = 36;
   localparam int FWD_ADDR_LO = 32;

   typedef struct packed {
      logic        valid;
      logic        we;
      logic        is_load;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } fwd_slot_t;

   // A slot only writes when it is real, writes, and does not target r0.
   function automatic logic slot_eff_we(input fwd_slot_t s);
      return s.valid & s.we & (s.waddr != 5'd0);
   endfunction

   function automatic logic [FWD_BUS_WD-1:0] pack_bus(input logic        we,
                                                      input logic [4:0]  waddr,
                                                      input logic [31:0] wdata);
      return {we, waddr, wdata};
   endfunction

   function automatic logic read_hit(input logic re1, input logic [4:0] raddr1,
                                     input logic re2, input logic [4:0] raddr2,
                                     input logic [4:0] waddr);
      return (re1 & (raddr1 == waddr)) | (re2 & (raddr2 == waddr));
   endfunction

endpackage

// File: rtl/fwd_source_if.sv
// fwd_source_if: EX/ID-side inputs and bypass/regfile outputs of fwd_source.
//   master : the bypass producer (fwd_source) - drives the buses, rf port, stall
//   slave  : the surrounding pipeline - drives EX fields, load data, ID reads
interface fwd_source_if;
   logic        ex_valid;
   logic        ex_we;
   logic        ex_is_load;
   logic [4:0]  ex_waddr;
   logic [31:0] ex_wdata;
   logic [31:0] mem_load_data;
   logic        id_re1;
   logic        id_re2;
   logic [4:0]  id_raddr1;
   logic [4:0]  id_raddr2;
   logic [37:0] ex_to_id_bus;
   logic [37:0] mem_to_id_bus;
   logic [37:0] wb_to_id_bus;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        stallreq_load;

   modport master (
      input  ex_valid, ex_we, ex_is_load, ex_waddr, ex_wdata, mem_load_data,
      input  id_re1, id_re2, id_raddr1, id_raddr2,
      output ex_to_id_bus, mem_to_id_bus, wb_to_id_bus,
      output rf_we, rf_waddr, rf_wdata, stallreq_load
   );

   modport slave (
      output ex_valid, ex_we, ex_is_load, ex_waddr, ex_wdata, mem_load_data,
      output id_re1, id_re2, id_raddr1, id_raddr2,
      input  ex_to_id_bus, mem_to_id_bus, wb_to_id_bus,
      input  rf_we, rf_waddr, rf_wdata, stallreq_load
   );
endinterface

// File: rtl/fwd_source_slot.sv
// fwd_slot: one pipeline stage register holding an in-flight write record.
//   clk, rst : clock, synchronous active-high reset (clears to an empty slot)
//   adv      : 1 = load a new record, 0 = hold
//   bubble   : with adv, load an empty slot instead of d
//   d / q    : incoming / held record
module fwd_slot
   import fwd_source_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      adv,
   input  logic      bubble,
   input  fwd_slot_t d,
   output fwd_slot_t q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (adv) begin
         // A bubble is fully zeroed so an empty slot shows an all-zero bus.
         q <= bubble ? '0 : d;
      end
   end

endmodule

// File: rtl/fwd_source.sv
// fwd_source: producer side of the ID-stage operand bypass.
// Tracks in-flight GPR writes in a MEM and a WB slot and drives the EX/MEM/WB
// bypass buses ({we, waddr, wdata}), the register-file write port from WB, and
// the load-use stall request.
//   clk, rst : clock, synchronous active-high reset
//   adv      : pipeline advance (0 = both slots hold)
//   flush    : squash the EX instruction; MEM loads a bubble
//   bus_if   : fwd_source_if.master - EX/ID inputs, bypass buses, rf port, stall
// Build option FWD_WB_EN: when defined the WB slot forwards on wb_to_id_bus;
// when undefined that bus is tied to 0 and a read hitting the WB write stalls
// instead, until the register-file write has landed.
module fwd_source
   import fwd_source_pkg::*;
(
   input logic          clk,
   input logic          rst,
   input logic          adv,
   input logic          flush,
   fwd_source_if.master bus_if
);

   fwd_slot_t ex_rec;
   fwd_slot_t mem_q;
   fwd_slot_t mem_res;
   fwd_slot_t wb_q;
   logic      mem_bubble;
   logic      ex_fwd_we;
   logic      ex_load_hit;
   logic      wb_hit;
   logic      unused_wb_is_load;

   always_comb begin
      ex_rec.valid   = bus_if.ex_valid;
      ex_rec.we      = bus_if.ex_we;
      ex_rec.is_load = bus_if.ex_is_load;
      ex_rec.waddr   = bus_if.ex_waddr;
      ex_rec.wdata   = bus_if.ex_wdata;
   end

   assign mem_bubble = flush | ~bus_if.ex_valid;

   fwd_slot u_mem (
      .clk    (clk),
      .rst    (rst),
      .adv    (adv),
      .bubble (mem_bubble),
      .d      (ex_rec),
      .q      (mem_q)
   );

   // Load data only exists during MEM, so it is folded in before WB latches it.
   always_comb begin
      mem_res = mem_q;
      if (mem_q.is_load) begin
         mem_res.wdata = bus_if.mem_load_data;
      end
   end

   fwd_slot u_wb (
      .clk    (clk),
      .rst    (rst),
      .adv    (adv),
      .bubble (1'b0),
      .d      (mem_res),
      .q      (wb_q)
   );

   // A load's result is not known in EX, so it never forwards from there.
   assign ex_fwd_we = bus_if.ex_valid & bus_if.ex_we & ~bus_if.ex_is_load &
                      (bus_if.ex_waddr != 5'd0);

   assign ex_load_hit = bus_if.ex_valid & bus_if.ex_we & bus_if.ex_is_load &
                        (bus_if.ex_waddr != 5'd0) &
                        read_hit(bus_if.id_re1, bus_if.id_raddr1,
                                 bus_if.id_re2, bus_if.id_raddr2, bus_if.ex_waddr);

   assign bus_if.ex_to_id_bus  = pack_bus(ex_fwd_we, bus_if.ex_waddr, bus_if.ex_wdata);
   assign bus_if.mem_to_id_bus = pack_bus(slot_eff_we(mem_q), mem_res.waddr, mem_res.wdata);

`ifdef FWD_WB_EN
   assign bus_if.wb_to_id_bus = pack_bus(slot_eff_we(wb_q), wb_q.waddr, wb_q.wdata);
   assign wb_hit              = 1'b0;
`else
   assign bus_if.wb_to_id_bus = '0;
   assign wb_hit              = slot_eff_we(wb_q) &
                                read_hit(bus_if.id_re1, bus_if.id_raddr1,
                                         bus_if.id_re2, bus_if.id_raddr2, wb_q.waddr);
`endif

   assign bus_if.stallreq_load = ex_load_hit | wb_hit;

   // A held WB write keeps rf_we high; rewriting the same value is harmless.
   assign bus_if.rf_we    = slot_eff_we(wb_q);
   assign bus_if.rf_waddr = wb_q.waddr;
   assign bus_if.rf_wdata = wb_q.wdata;

   assign unused_wb_is_load = wb_q.is_load;

endmodule

// File: tb/tb_fwd_source.sv
module tb_fwd_source;

   logic clk = 1'b0;
   logic rst, adv, flush;
   always #5 clk = ~clk;

   fwd_source_if bif ();

   fwd_source dut (
      .clk    (clk),
      .rst    (rst),
      .adv    (adv),
      .flush  (flush),
      .bus_if (bif)
   );

   typedef struct {
      logic [37:0] ex_bus;
      logic [37:0] mem_bus;
      logic [37:0] wb_bus;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] rf_wdata;
      logic        stall;
   } exp_t;

   // In-flight write as the architecture sees it: who writes what, and whether
   // the value still has to come back from memory.
   typedef struct {
      bit        real_instr;
      bit        writes;
      bit        load;
      bit [4:0]  dest;
      bit [31:0] value;
   } flight_t;

   exp_t    exp_q[$];
   flight_t in_mem, in_wb;
   bit      model_known = 0;
   int      n_checks = 0;
   int      n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic bit reads(input bit [4:0] r);
      return (bif.id_re1 && bif.id_raddr1 == r) || (bif.id_re2 && bif.id_raddr2 == r);
   endfunction

   function automatic exp_t predict();
      exp_t    e;
      flight_t m;
      bit      mem_w, wb_w, ex_w;
      m      = in_mem;
      if (m.load) m.value = bif.mem_load_data;
      ex_w   = bif.ex_valid && bif.ex_we && !bif.ex_is_load && bif.ex_waddr != 0;
      mem_w  = m.real_instr && m.writes && m.dest != 0;
      wb_w   = in_wb.real_instr && in_wb.writes && in_wb.dest != 0;
      e.ex_bus   = {ex_w, bif.ex_waddr, bif.ex_wdata};
      e.mem_bus  = m.real_instr ? {mem_w, m.dest, m.value} : 38'd0;
`ifdef FWD_WB_EN
      e.wb_bus   = in_wb.real_instr ? {wb_w, in_wb.dest, in_wb.value} : 38'd0;
`else
      e.wb_bus   = 38'd0;
`endif
      e.rf_we    = wb_w;
      e.rf_waddr = in_wb.real_instr ? in_wb.dest  : 5'd0;
      e.rf_wdata = in_wb.real_instr ? in_wb.value : 32'd0;
      e.stall    = bif.ex_valid && bif.ex_we && bif.ex_is_load && bif.ex_waddr != 0 &&
                   reads(bif.ex_waddr);
`ifndef FWD_WB_EN
      e.stall    = e.stall || (wb_w && reads(in_wb.dest));
`endif
      return e;
   endfunction

   // One clock: queue this cycle's expectation, then retire the edge in the model.
   task automatic cycle();
      flight_t empty = '{default: 0};
      flight_t m;
      if (model_known) exp_q.push_back(predict());
      @(posedge clk);
      if (rst) begin
         in_mem      = empty;
         in_wb       = empty;
         model_known = 1;
      end else if (adv) begin
         m = in_mem;
         if (m.load) m.value = bif.mem_load_data;
         in_wb  = m;
         in_mem = (flush || !bif.ex_valid) ? empty :
                  '{1, bif.ex_we, bif.ex_is_load, bif.ex_waddr, bif.ex_wdata};
      end
      #1;
   endtask

   task automatic set_ex(input bit v, input bit we, input bit ld, input bit [4:0] a,
                         input bit [31:0] d);
      bif.ex_valid = v; bif.ex_we = we; bif.ex_is_load = ld;
      bif.ex_waddr = a; bif.ex_wdata = d;
   endtask

   task automatic set_id(input bit re1, input bit [4:0] a1, input bit re2, input bit [4:0] a2);
      bif.id_re1 = re1; bif.id_raddr1 = a1; bif.id_re2 = re2; bif.id_raddr2 = a2;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ex_to_id_bus",  bif.ex_to_id_bus,  e.ex_bus);
            check("mem_to_id_bus", bif.mem_to_id_bus, e.mem_bus);
            check("wb_to_id_bus",  bif.wb_to_id_bus,  e.wb_bus);
            check("rf_we",         bif.rf_we,         e.rf_we);
            check("rf_waddr",      bif.rf_waddr,      e.rf_waddr);
            check("rf_wdata",      bif.rf_wdata,      e.rf_wdata);
            check("stallreq_load", bif.stallreq_load, e.stall);
         end
      end
   end

   initial begin : stimulus
      rst = 1; adv = 1; flush = 0;
      set_ex(0, 0, 0, 0, 0);
      set_id(0, 0, 0, 0);
      bif.mem_load_data = 32'h0;
      cycle();
      cycle();
      #1;
      check("reset_mem_bus", bif.mem_to_id_bus, 38'd0);
      check("reset_rf_we",   bif.rf_we, 1'b0);
      rst = 0;

      // ALU write r5 through the pipe
      set_ex(1, 1, 0, 5, 32'h1234);
      #1; check("ex_bus_r5", bif.ex_to_id_bus, 38'h25_0000_1234);
      cycle();
      set_ex(0, 0, 0, 0, 0);
      #1; check("mem_bus_r5", bif.mem_to_id_bus, 38'h25_0000_1234);
      cycle();
      #1; check("rf_r5", {bif.rf_we, bif.rf_waddr, bif.rf_wdata}, {1'b1, 5'd5, 32'h1234});

      // load-use on r7
      set_ex(1, 1, 1, 7, 32'h5555);
      set_id(0, 0, 1, 7);
      #1; check("load_stall", bif.stallreq_load, 1'b1);
      check("load_ex_we", bif.ex_to_id_bus[37], 1'b0);
      cycle();
      set_ex(0, 0, 0, 0, 0);
      set_id(0, 0, 0, 0);
      bif.mem_load_data = 32'hDEADBEEF;
      #1; check("load_mem_bus", bif.mem_to_id_bus, {1'b1, 5'd7, 32'hDEADBEEF});
      cycle();
      bif.mem_load_data = 32'h0;
      #1; check("load_wb_data", bif.rf_wdata, 32'hDEADBEEF);

      // writes to r0 never forward or stall
      set_ex(1, 1, 0, 0, 32'hFFFF_FFFF);
      set_id(1, 0, 1, 0);
      #1; check("r0_ex_we", bif.ex_to_id_bus[37], 1'b0);
      check("r0_stall", bif.stallreq_load, 1'b0);
      cycle();
      set_ex(0, 0, 0, 0, 0);
      set_id(0, 0, 0, 0);
      #1; check("r0_mem_we", bif.mem_to_id_bus[37], 1'b0);
      cycle();
      #1; check("r0_rf_we", bif.rf_we, 1'b0);

      // hold with MEM=r3, WB=r4
      set_ex(1, 1, 0, 4, 32'h4444);
      cycle();
      set_ex(1, 1, 0, 3, 32'h3333);
      cycle();
      set_ex(1, 1, 0, 9, 32'h9999);
      flush = 1;
      adv = 0;
      for (int i = 0; i < 3; i++) begin
         #1; check("hold_rf", {bif.rf_we, bif.rf_waddr}, {1'b1, 5'd4});
         check("hold_mem", bif.mem_to_id_bus, {1'b1, 5'd3, 32'h3333});
         cycle();
      end
      flush = 0;
      adv = 1;
      set_ex(0, 0, 0, 0, 0);
      cycle();
      #1; check("release_rf", bif.rf_waddr, 5'd3);

      // flush r9
      set_ex(1, 1, 0, 9, 32'h9999);
      flush = 1;
      cycle();
      flush = 0;
      set_ex(1, 1, 0, 10, 32'hAAAA);
      #1; check("flush_mem", bif.mem_to_id_bus, 38'd0);
      cycle();
      set_ex(1, 1, 0, 11, 32'hBBBB);
      // reset mid-flight
      rst = 1;
      cycle();
      rst = 0;
      set_ex(0, 0, 0, 0, 0);
      #1; check("rst_mid_mem", bif.mem_to_id_bus, 38'd0);
      check("rst_mid_rf", bif.rf_we, 1'b0);

      // r6 reaching WB while ID reads it
      set_ex(1, 1, 0, 6, 32'h6666);
      cycle();
      set_ex(0, 0, 0, 0, 0);
      cycle();
      set_id(1, 6, 0, 0);
`ifndef FWD_WB_EN
      #1; check("wb_stall_on", bif.stallreq_load, 1'b1);
      check("wb_bus_tied", bif.wb_to_id_bus, 38'd0);
`endif
      cycle();
`ifndef FWD_WB_EN
      #1; check("wb_stall_off", bif.stallreq_load, 1'b0);
`endif
      cycle();

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         rst   = ($urandom_range(0, 49) == 0);
         adv   = ($urandom_range(0, 4) != 0);
         flush = ($urandom_range(0, 9) == 0);
         set_ex($urandom_range(0, 5) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom);
         set_id(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
         bif.mem_load_data = $urandom;
         cycle();
      end
      rst = 0;

      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
